// File: rtl/axis_testpattern_checker_if.sv
// AXI-Stream bus bundle between a test-pattern master and the checker.
// Ports/signals:
//   tdata  - stream data, TDATA_WIDTH bits
//   tvalid - master has a beat
//   tready - slave can accept a beat
// Modports: master drives tdata/tvalid, slave drives tready.
interface axis_testpattern_checker_if #(
  parameter int TDATA_WIDTH = 8
);
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tvalid;
  logic                   tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_testpattern_checker.sv
// AXI-Stream slave that locks onto a START..END/INCR counter ramp, checks
// every accepted beat, counts beats and mismatches, flags stream-stability
// violations and throttles tready with a programmable duty cycle.
// Ports:
//   s_axis_aclk, s_axis_aresetn - clock, async active-low reset
//   enable         - 0 forces tready low and freezes divider/state
//   clear          - sync pulse: zero counters/flags, back to HUNT
//   s_axis         - stream slave (tdata, tvalid, tready)
//   locked         - checker is in LOCKED
//   seq_error      - sticky sequence-mismatch flag
//   protocol_error - sticky stall-stability violation flag
//   err_count      - saturating mismatch counter
//   beat_count     - accepted beats, wraps
//   last_bad_data  - tdata of latest mismatching beat
//   last_exp_data  - expected value at latest mismatch
module axis_testpattern_checker #(
  parameter int S00_AXIS_TDATA_WIDTH = 8,
  parameter int COUNTER_START        = -10,
  parameter int COUNTER_END          = 10,
  parameter int COUNTER_INCR         = 1,
  parameter int READY_DIVIDER        = 1,
  parameter int ERR_COUNT_WIDTH      = 16
) (
  input  logic                            s_axis_aclk,
  input  logic                            s_axis_aresetn,
  input  logic                            enable,
  input  logic                            clear,
  axis_testpattern_checker_if.slave       s_axis,
  output logic                            locked,
  output logic                            seq_error,
  output logic                            protocol_error,
  output logic [ERR_COUNT_WIDTH-1:0]      err_count,
  output logic [31:0]                     beat_count,
  output logic [S00_AXIS_TDATA_WIDTH-1:0] last_bad_data,
  output logic [S00_AXIS_TDATA_WIDTH-1:0] last_exp_data
);

  localparam int unsigned DW    = S00_AXIS_TDATA_WIDTH;
  localparam int unsigned EW    = ERR_COUNT_WIDTH;
  localparam int unsigned DIV_W = (READY_DIVIDER > 1) ? $clog2(READY_DIVIDER) : 1;

  localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(READY_DIVIDER - 1);
  localparam logic signed [DW-1:0] C_START  = DW'(COUNTER_START);
  localparam logic signed [DW-1:0] C_END    = DW'(COUNTER_END);
  localparam logic signed [DW-1:0] C_INCR   = DW'(COUNTER_INCR);

  localparam logic [0:0] S_HUNT   = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;

  // Successor of v on the ramp, wrapping END back to START.
  function automatic logic signed [DW-1:0] f_next(input logic signed [DW-1:0] v);
    return (v == C_END) ? C_START : (v + C_INCR);
  endfunction

  // Signed membership test for the ramp's value range.
  function automatic logic f_in_range(input logic signed [DW-1:0] v);
    return (v >= C_START) && (v <= C_END);
  endfunction

  logic [0:0]             r_state;
  logic [0:0]             w_state_nxt;
  logic signed [DW-1:0]   r_expected;
  logic signed [DW-1:0]   w_exp_nxt;
  logic                   w_mismatch;
  logic [DIV_W-1:0]       r_div;
  logic [DIV_W-1:0]       w_div_nxt;
  logic                   r_tready;
  logic                   r_stall;
  logic [DW-1:0]          r_stall_data;
  logic                   r_locked;
  logic                   r_seq_error;
  logic                   r_protocol_error;
  logic [EW-1:0]          r_err_count;
  logic [31:0]            r_beat_count;
  logic [DW-1:0]          r_last_bad;
  logic [DW-1:0]          r_last_exp;
  logic signed [DW-1:0]   w_tdata;
  logic                   w_accept;
  logic                   w_proto_viol;

  assign w_tdata  = s_axis.tdata;
  assign w_accept = s_axis.tvalid & r_tready;

  // A stalled beat must stay valid with unchanged data into the next cycle.
  assign w_proto_viol = r_stall & (~s_axis.tvalid | (s_axis.tdata != r_stall_data));

  assign w_div_nxt = (r_div == DIV_LAST) ? '0 : (r_div + DIV_W'(1));

  // Ready duty-cycle generator; tready is high when the divider sits at its last count.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_div    <= '0;
      r_tready <= 1'b0;
    end else if (enable) begin
      r_div    <= w_div_nxt;
      r_tready <= (w_div_nxt == DIV_LAST);
    end else begin
      r_tready <= 1'b0;
    end
  end

  // State register.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_state    <= S_HUNT;
      r_expected <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_expected <= w_exp_nxt;
    end
  end

  // Next state / expected value; clear overrides any accepted beat.
  always_comb begin
    w_state_nxt = r_state;
    w_exp_nxt   = r_expected;
    w_mismatch  = 1'b0;
    if (w_accept) begin
      case (r_state)
        S_HUNT: begin
          if (f_in_range(w_tdata)) begin
            w_exp_nxt   = f_next(w_tdata);
            w_state_nxt = S_LOCKED;
          end
        end
        S_LOCKED: begin
          if (w_tdata == r_expected) begin
            w_exp_nxt = f_next(r_expected);
          end else begin
            w_mismatch = 1'b1;
            if (f_in_range(w_tdata)) begin
              w_exp_nxt = f_next(w_tdata);
            end else begin
              w_state_nxt = S_HUNT;
            end
          end
        end
        default: w_state_nxt = S_HUNT;
      endcase
    end
    if (clear) begin
      w_state_nxt = S_HUNT;
      w_mismatch  = 1'b0;
    end
  end

  // Stall snapshot used by the stability check, tracked regardless of enable/clear.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_stall      <= 1'b0;
      r_stall_data <= '0;
    end else begin
      r_stall      <= s_axis.tvalid & ~r_tready;
      r_stall_data <= s_axis.tdata;
    end
  end

  // Counters, sticky flags and mismatch capture.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_locked         <= 1'b0;
      r_seq_error      <= 1'b0;
      r_protocol_error <= 1'b0;
      r_err_count      <= '0;
      r_beat_count     <= '0;
      r_last_bad       <= '0;
      r_last_exp       <= '0;
    end else begin
      r_locked <= (w_state_nxt == S_LOCKED);
      if (clear) begin
        r_seq_error      <= 1'b0;
        r_protocol_error <= 1'b0;
        r_err_count      <= '0;
        r_beat_count     <= '0;
        r_last_bad       <= '0;
        r_last_exp       <= '0;
      end else begin
        if (w_accept) begin
          r_beat_count <= r_beat_count + 32'd1;
        end
        if (w_mismatch) begin
          if (r_err_count != '1) begin
            r_err_count <= r_err_count + EW'(1);
          end
          r_seq_error <= 1'b1;
          r_last_bad  <= w_tdata;
          r_last_exp  <= r_expected;
        end
        if (w_proto_viol) begin
          r_protocol_error <= 1'b1;
        end
      end
    end
  end

  assign s_axis.tready  = r_tready;
  assign locked         = r_locked;
  assign seq_error      = r_seq_error;
  assign protocol_error = r_protocol_error;
  assign err_count      = r_err_count;
  assign beat_count     = r_beat_count;
  assign last_bad_data  = r_last_bad;
  assign last_exp_data  = r_last_exp;

endmodule

// File: tb/tb_axis_testpattern_checker.sv
// Directed bench: dut1 (always ready) gets table-driven beats and hand-written
// corner sequences; dut4 (ready 1-in-4) is fed by a ramp-generator model.
module tb_axis_testpattern_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1_n, rst4_n, en1, en4, clr1, clr4;

  axis_testpattern_checker_if #(.TDATA_WIDTH(8)) if1 ();
  axis_testpattern_checker_if #(.TDATA_WIDTH(8)) if4 ();

  logic        lk1, se1, pe1, lk4, se4, pe4;
  logic [15:0] ec1, ec4;
  logic [31:0] bc1, bc4;
  logic [7:0]  lb1, le1, lb4, le4;

  axis_testpattern_checker #(.READY_DIVIDER(1)) dut1 (
    .s_axis_aclk(clk), .s_axis_aresetn(rst1_n), .enable(en1), .clear(clr1),
    .s_axis(if1.slave), .locked(lk1), .seq_error(se1), .protocol_error(pe1),
    .err_count(ec1), .beat_count(bc1), .last_bad_data(lb1), .last_exp_data(le1));

  axis_testpattern_checker #(.READY_DIVIDER(4)) dut4 (
    .s_axis_aclk(clk), .s_axis_aresetn(rst4_n), .enable(en4), .clear(clr4),
    .s_axis(if4.slave), .locked(lk4), .seq_error(se4), .protocol_error(pe4),
    .err_count(ec4), .beat_count(bc4), .last_bad_data(lb4), .last_exp_data(le4));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gnext(input logic [7:0] v);
    return (v == 8'h0A) ? 8'hF6 : (v + 8'd1);
  endfunction

  // Present one beat on if1 at a negedge, wait for ready (bounded), let it be taken.
  task automatic beat(input logic [7:0] d);
    int w;
    if1.tvalid = 1'b1;
    if1.tdata  = d;
    w = 0;
    while (if1.tready !== 1'b1 && w < 16) begin
      @(negedge clk);
      w++;
    end
    chk("beat_ready", {31'b0, if1.tready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  data;
    logic        lk;
    logic        se;
    logic [15:0] ec;
    logic [31:0] bc;
    logic [7:0]  lb;
    logic [7:0]  le;
  } vec_t;

  vec_t tbl [13];

  initial begin
    logic [7:0] v;
    logic [7:0] g;
    logic       t;
    int         hs, hi_cnt, last_hi;

    tbl[0]  = '{8'hF6, 1'b1, 1'b0, 16'd0, 32'd1,  8'h00, 8'h00};
    tbl[1]  = '{8'hF7, 1'b1, 1'b0, 16'd0, 32'd2,  8'h00, 8'h00};
    tbl[2]  = '{8'hF9, 1'b1, 1'b1, 16'd1, 32'd3,  8'hF9, 8'hF8};
    tbl[3]  = '{8'hFA, 1'b1, 1'b1, 16'd1, 32'd4,  8'hF9, 8'hF8};
    tbl[4]  = '{8'h40, 1'b0, 1'b1, 16'd2, 32'd5,  8'h40, 8'hFB};
    tbl[5]  = '{8'h03, 1'b1, 1'b1, 16'd2, 32'd6,  8'h40, 8'hFB};
    tbl[6]  = '{8'h04, 1'b1, 1'b1, 16'd2, 32'd7,  8'h40, 8'hFB};
    tbl[7]  = '{8'h0A, 1'b1, 1'b1, 16'd3, 32'd8,  8'h0A, 8'h05};
    tbl[8]  = '{8'hF6, 1'b1, 1'b1, 16'd3, 32'd9,  8'h0A, 8'h05};
    tbl[9]  = '{8'h80, 1'b0, 1'b1, 16'd4, 32'd10, 8'h80, 8'hF7};
    tbl[10] = '{8'h0B, 1'b0, 1'b1, 16'd4, 32'd11, 8'h80, 8'hF7};
    tbl[11] = '{8'h0A, 1'b1, 1'b1, 16'd4, 32'd12, 8'h80, 8'hF7};
    tbl[12] = '{8'hF6, 1'b1, 1'b1, 16'd4, 32'd13, 8'h80, 8'hF7};

    rst1_n = 1'b0; rst4_n = 1'b0;
    en1 = 1'b1; en4 = 1'b1; clr1 = 1'b0; clr4 = 1'b0;
    if1.tvalid = 1'b0; if1.tdata = 8'h00;
    if4.tvalid = 1'b0; if4.tdata = 8'h00;

    // Reset values
    #2;
    chk("rst_tready", {31'b0, if1.tready}, 32'd0);
    chk("rst_locked", {31'b0, lk1}, 32'd0);
    chk("rst_seq",    {31'b0, se1}, 32'd0);
    chk("rst_proto",  {31'b0, pe1}, 32'd0);
    chk("rst_err",    {16'b0, ec1}, 32'd0);
    chk("rst_beats",  bc1, 32'd0);
    chk("rst_last",   {16'b0, lb1, le1}, 32'd0);
    repeat (2) @(negedge clk);
    rst1_n = 1'b1; rst4_n = 1'b1;
    @(negedge clk);

    // 100-beat clean ramp including wraps
    v = 8'hF6;
    for (int i = 0; i < 100; i++) begin
      beat(v);
      if (i == 0) chk("ramp_first_lock", {31'b0, lk1}, 32'd1);
      if (i == 21) begin
        chk("ramp_wrap_err",  {16'b0, ec1}, 32'd0);
        chk("ramp_wrap_lock", {31'b0, lk1}, 32'd1);
      end
      v = gnext(v);
    end
    if1.tvalid = 1'b0;
    chk("ramp_beats", bc1, 32'd100);
    chk("ramp_err",   {16'b0, ec1}, 32'd0);
    chk("ramp_seq",   {31'b0, se1}, 32'd0);
    chk("ramp_lock",  {31'b0, lk1}, 32'd1);

    clr1 = 1'b1;
    @(negedge clk);
    clr1 = 1'b0;
    chk("clr_beats", bc1, 32'd0);
    chk("clr_lock",  {31'b0, lk1}, 32'd0);

    // Table: gap/resync, out-of-range drop, re-lock, END boundary, wrap
    for (int i = 0; i < 13; i++) begin
      beat(tbl[i].data);
      chk($sformatf("vec%0d_locked", i), {31'b0, lk1}, {31'b0, tbl[i].lk});
      chk($sformatf("vec%0d_seq", i),    {31'b0, se1}, {31'b0, tbl[i].se});
      chk($sformatf("vec%0d_err", i),    {16'b0, ec1}, {16'b0, tbl[i].ec});
      chk($sformatf("vec%0d_beats", i),  bc1, tbl[i].bc);
      chk($sformatf("vec%0d_bad", i),    {24'b0, lb1}, {24'b0, tbl[i].lb});
      chk($sformatf("vec%0d_exp", i),    {24'b0, le1}, {24'b0, tbl[i].le});
    end
    if1.tvalid = 1'b0;

    // Clear zeroes counters, sticky flags and capture registers
    clr1 = 1'b1;
    @(negedge clk);
    clr1 = 1'b0;
    chk("clr2_err",  {16'b0, ec1}, 32'd0);
    chk("clr2_seq",  {31'b0, se1}, 32'd0);
    chk("clr2_last", {16'b0, lb1, le1}, 32'd0);
    chk("clr2_lock", {31'b0, lk1}, 32'd0);

    // Stall with data change -> sticky protocol error
    en1 = 1'b0;
    @(negedge clk);
    chk("dis_tready", {31'b0, if1.tready}, 32'd0);
    if1.tvalid = 1'b1; if1.tdata = 8'h05;
    @(negedge clk);
    chk("stall_hold_proto", {31'b0, pe1}, 32'd0);
    if1.tdata = 8'h06;
    @(negedge clk);
    chk("stall_change_proto", {31'b0, pe1}, 32'd1);
    repeat (2) @(negedge clk);
    chk("proto_sticky", {31'b0, pe1}, 32'd1);
    chk("stall_beats",  bc1, 32'd0);
    clr1 = 1'b1; if1.tvalid = 1'b0;
    @(negedge clk);
    clr1 = 1'b0;
    chk("proto_clear", {31'b0, pe1}, 32'd0);
    en1 = 1'b1;
    @(negedge clk);

    // Mid-stream reset, then clear coincident with a handshake
    beat(8'hF6);
    beat(8'hF8);
    chk("pre_rst_err", {16'b0, ec1}, 32'd1);
    if1.tvalid = 1'b0;
    rst1_n = 1'b0;
    #1;
    chk("mrst_tready", {31'b0, if1.tready}, 32'd0);
    chk("mrst_lock",   {31'b0, lk1}, 32'd0);
    chk("mrst_err",    {16'b0, ec1}, 32'd0);
    chk("mrst_seq",    {31'b0, se1}, 32'd0);
    chk("mrst_beats",  bc1, 32'd0);
    chk("mrst_last",   {16'b0, lb1, le1}, 32'd0);
    @(negedge clk);
    rst1_n = 1'b1;
    @(negedge clk);
    if1.tvalid = 1'b1; if1.tdata = 8'h03; clr1 = 1'b1;
    chk("clrhs_tready", {31'b0, if1.tready}, 32'd1);
    @(negedge clk);
    clr1 = 1'b0; if1.tdata = 8'h04;
    chk("clrhs_beats", bc1, 32'd0);
    chk("clrhs_lock",  {31'b0, lk1}, 32'd0);
    @(negedge clk);
    if1.tvalid = 1'b0;
    chk("relock_lock",  {31'b0, lk1}, 32'd1);
    chk("relock_beats", bc1, 32'd1);
    chk("relock_err",   {16'b0, ec1}, 32'd0);
    chk("relock_seq",   {31'b0, se1}, 32'd0);

    // READY_DIVIDER=4 fed by a generator model that holds data while stalled
    g = 8'hF6; hs = 0; hi_cnt = 0; last_hi = -1;
    if4.tvalid = 1'b1; if4.tdata = g;
    for (int c = 0; c < 200; c++) begin
      t = if4.tready;
      if (t) begin
        if (last_hi >= 0) chk("div4_gap", c - last_hi, 32'd4);
        last_hi = c;
        hi_cnt++;
      end
      @(negedge clk);
      if (t) begin
        hs++;
        g = gnext(g);
        if4.tdata = g;
      end
    end
    if4.tvalid = 1'b0;
    chk("div4_ready_cnt", hi_cnt, 32'd50);
    chk("div4_beats", bc4, 32'd50);
    chk("div4_err",   {16'b0, ec4}, 32'd0);
    chk("div4_seq",   {31'b0, se4}, 32'd0);
    chk("div4_proto", {31'b0, pe4}, 32'd0);
    chk("div4_lock",  {31'b0, lk4}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
